// File: rtl/fetch_inst_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_inst_queue_if
//   Bundles the IF1 push side, the decode pop side and the status outputs of
//   fetch_inst_queue.
//   master : the IF1/decode side. It drives flush, the push packet and pop_cnt.
//   slave  : the queue. It drives push_ready, the two output slots and
//            count/empty/full.
// -----------------------------------------------------------------------------
interface fetch_inst_queue_if #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 32,
  parameter int META_W = 43
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              push_valid;
  logic [1:0]        push_mask;
  logic [INST_W-1:0] push_inst0;
  logic [INST_W-1:0] push_inst1;
  logic [31:0]       push_pc;
  logic [META_W-1:0] push_meta;
  logic              push_ready;

  logic [1:0]        out_valid;
  logic [INST_W-1:0] out_inst0;
  logic [INST_W-1:0] out_inst1;
  logic [31:0]       out_pc0;
  logic [31:0]       out_pc1;
  logic [META_W-1:0] out_meta0;
  logic [META_W-1:0] out_meta1;
  logic [1:0]        pop_cnt;

  logic [CW-1:0]     count;
  logic              empty;
  logic              full;

  modport master (
    output flush, push_valid, push_mask, push_inst0, push_inst1, push_pc,
           push_meta, pop_cnt,
    input  push_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
           out_meta0, out_meta1, count, empty, full
  );

  modport slave (
    input  flush, push_valid, push_mask, push_inst0, push_inst1, push_pc,
           push_meta, pop_cnt,
    output push_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
           out_meta0, out_meta1, count, empty, full
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// -----------------------------------------------------------------------------
// fetch_inst_queue
//   Instruction-granular fetch queue between IF1 and decode. Each cycle it
//   accepts one 2-slot fetch packet. Invalid slots are compacted out on entry.
//   It presents the two oldest instructions to decode, and decode pops 0, 1 or
//   2 of them per cycle. When the queue is empty, an accepted packet is shown
//   on the outputs in the same cycle (bypass). Flush empties the queue in a
//   single cycle.
//
// Ports
//   clk   : clock
//   rstn  : asynchronous active-low reset. It clears the pointers and the
//           count. Storage is not reset.
//   bus   : fetch_inst_queue_if.slave
//     flush                 discard all contents; the push and pop in this
//                           cycle are ignored
//     push_valid/push_mask  packet valid and per-slot valid (bit0 = inst0)
//     push_inst0/1, push_pc instructions at push_pc and push_pc+4
//     push_meta             packet side info, copied to each instruction
//     push_ready            at least two entries are free
//     out_valid             00 / 01 / 11 mask for the two output slots
//     out_inst*/pc*/meta*   oldest (slot 0) and second-oldest (slot 1)
//     pop_cnt               instructions consumed this cycle (0..2)
//     count/empty/full      registered occupancy
// -----------------------------------------------------------------------------
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1c000000
`endif

module fetch_inst_queue #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 32,
  parameter int META_W = 43
) (
  input logic               clk,
  input logic               rstn,
  fetch_inst_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Storage (not reset)
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [META_W-1:0] meta_q [DEPTH];

  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_ready;
  logic          accept;
  logic          bypass;
  logic [1:0]    nv;
  logic [1:0]    nv_acc;
  logic [1:0]    avail;
  logic [1:0]    pop_eff;
  logic [1:0]    skip;
  logic [1:0]    nw;
  logic [AW-1:0] rptr_p1;
  logic [AW-1:0] wptr_p1;

  // Compacted incoming packet: c0 is the first valid instruction, c1 the second
  logic [INST_W-1:0] c0_inst, c1_inst;
  logic [31:0]       c0_pc, c1_pc;
  // Data for the two write ports after removing the instructions popped in bypass
  logic [INST_W-1:0] w0_inst;
  logic [31:0]       w0_pc;

  logic [1:0]        out_valid;
  logic [INST_W-1:0] out_inst0, out_inst1;
  logic [31:0]       out_pc0, out_pc1;
  logic [META_W-1:0] out_meta0, out_meta1;

  // Push-side decode
  always_comb begin
    push_ready = (count_q <= CW'(DEPTH - 2));
    accept     = bus.push_valid && push_ready && !bus.flush;
    bypass     = accept && (count_q == '0);
    nv         = popcnt2(bus.push_mask);
    nv_acc     = accept ? nv : 2'd0;
    rptr_p1    = rptr_q + AW'(1);
    wptr_p1    = wptr_q + AW'(1);
    c1_inst    = bus.push_inst1;
    c1_pc      = bus.push_pc + 32'd4;
    // When slot 0 is masked off (misaligned start), inst1 moves to the head.
    c0_inst    = bus.push_mask[0] ? bus.push_inst0 : bus.push_inst1;
    c0_pc      = bus.push_mask[0] ? bus.push_pc : c1_pc;
  end

  // Output slots
  always_comb begin
    out_valid = 2'b00;
    out_inst0 = INST_W'(`INST_NOP);
    out_inst1 = INST_W'(`INST_NOP);
    out_pc0   = `PC_RESET;
    out_pc1   = `PC_RESET;
    out_meta0 = '0;
    out_meta1 = '0;
    if (bus.flush) begin
      out_valid = 2'b00;
    end else if (bypass) begin
      if (nv != 2'd0) begin
        out_valid = 2'b01;
        out_inst0 = c0_inst;
        out_pc0   = c0_pc;
        out_meta0 = bus.push_meta;
      end
      if (nv == 2'd2) begin
        out_valid = 2'b11;
        out_inst1 = c1_inst;
        out_pc1   = c1_pc;
        out_meta1 = bus.push_meta;
      end
    end else if (count_q != '0) begin
      out_valid = 2'b01;
      out_inst0 = inst_q[rptr_q];
      out_pc0   = pc_q[rptr_q];
      out_meta0 = meta_q[rptr_q];
      if (count_q >= CW'(2)) begin
        out_valid = 2'b11;
        out_inst1 = inst_q[rptr_p1];
        out_pc1   = pc_q[rptr_p1];
        out_meta1 = meta_q[rptr_p1];
      end
    end
  end

  // Pop / write bookkeeping
  always_comb begin
    avail   = popcnt2(out_valid);
    // A pop_cnt above the valid slot count is clamped here. The assertion
    // below flags it in simulation.
    pop_eff = min2(bus.pop_cnt, avail);
    // Instructions consumed straight off the bypass path are never stored.
    // rptr then stays at wptr, because nothing was read from storage.
    skip    = bypass ? pop_eff : 2'd0;
    nw      = nv_acc - skip;
    w0_inst = (skip == 2'd0) ? c0_inst : c1_inst;
    w0_pc   = (skip == 2'd0) ? c0_pc   : c1_pc;

    rptr_d  = bypass ? rptr_q : rptr_q + AW'(pop_eff);
    wptr_d  = wptr_q + AW'(nw);
    count_d = count_q + CW'(nv_acc) - CW'(pop_eff);
    if (bus.flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage write. While flush is high, accept is low, so nw is 0.
  always_ff @(posedge clk) begin
    if (nw != 2'd0) begin
      inst_q[wptr_q] <= w0_inst;
      pc_q[wptr_q]   <= w0_pc;
      meta_q[wptr_q] <= bus.push_meta;
    end
    if (nw == 2'd2) begin
      inst_q[wptr_p1] <= c1_inst;
      pc_q[wptr_p1]   <= c1_pc;
      meta_q[wptr_p1] <= bus.push_meta;
    end
  end

  assign bus.push_ready = push_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_inst0  = out_inst0;
  assign bus.out_inst1  = out_inst1;
  assign bus.out_pc0    = out_pc0;
  assign bus.out_pc1    = out_pc1;
  assign bus.out_meta0  = out_meta0;
  assign bus.out_meta1  = out_meta1;
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);
  assign bus.full       = (count_q == CW'(DEPTH));

`ifndef SYNTHESIS
  // Decode must not pop more instructions than the valid output slots.
  pop_within_valid: assert property (@(posedge clk) disable iff (!rstn)
    !bus.flush |-> (bus.pop_cnt <= popcnt2(out_valid)));
`endif

endmodule
